// File: rtl/image_pkg.sv
// -----------------------------------------------------------------------------
// image_pkg
// Shared definitions for the image_writer block: the writer FSM state encoding,
// bus widths and the RGBA8888 -> RGB5551 pixel packing helper.
// -----------------------------------------------------------------------------
package image_pkg;

   localparam int ADDR_W  = 20;
   localparam int DATA_W  = 16;
   localparam int PIX_W   = 32;
   localparam int TIMER_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_SETUP = 3'd2,
      ST_WRITE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // Keep the top five bits of each colour channel and the alpha MSB.
   function automatic logic [DATA_W-1:0] pack_rgb5551(input logic [PIX_W-1:0] px);
      return {px[31:27], px[23:19], px[15:11], px[7]};
   endfunction

endpackage

// File: rtl/image_writer_if.sv
// -----------------------------------------------------------------------------
// image_writer_if
// Frame control and pixel stream handshake of the image_writer.
//   i_start / i_base_address : frame start request and first SRAM word address
//   i_valid / i_pixel        : RGBA8888 pixel stream from the producer
//   o_ready                  : writer can take a pixel this cycle
//   o_busy / o_done / o_count: frame status
// master = pixel producer / controller, slave = image_writer.
// -----------------------------------------------------------------------------
interface image_writer_if;
   import image_pkg::*;

   logic              i_start;
   logic [ADDR_W-1:0] i_base_address;
   logic              i_valid;
   logic [PIX_W-1:0]  i_pixel;
   logic              o_ready;
   logic              o_busy;
   logic              o_done;
   logic [ADDR_W-1:0] o_count;

   modport master (
      output i_start, i_base_address, i_valid, i_pixel,
      input  o_ready, o_busy, o_done, o_count
   );

   modport slave (
      input  i_start, i_base_address, i_valid, i_pixel,
      output o_ready, o_busy, o_done, o_count
   );

endinterface

// File: rtl/image_writer_sram_write_timer.sv
// -----------------------------------------------------------------------------
// sram_write_timer
// Down-counter that times the SRAM write-enable low pulse.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_load  : load WR_CYCLES; asserted in the cycle before the pulse starts
//   o_done  : high in the last cycle of the pulse
// -----------------------------------------------------------------------------
module sram_write_timer
   import image_pkg::*;
#(
   parameter int unsigned WR_CYCLES = 2
)
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   output logic o_done
);

   logic [TIMER_W-1:0] timer_q;
   logic [TIMER_W-1:0] timer_d;

   // Next timer value: reload, or count down and park at zero.
   always_comb begin
      timer_d = timer_q;
      if (i_load) begin
         timer_d = TIMER_W'(WR_CYCLES);
      end else if (timer_q != 4'd0) begin
         timer_d = timer_q - 4'd1;
      end else begin
         timer_d = timer_q;
      end
   end

   // Timer register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timer_q <= 4'd0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // The first pulse cycle holds WR_CYCLES, so a value of one marks the last.
   assign o_done = (timer_q == 4'd1);

endmodule

// File: rtl/image_writer.sv
// -----------------------------------------------------------------------------
// image_writer
// Writes one frame of RGBA8888 pixels into a 16-bit asynchronous SRAM as
// RGB5551 words at consecutive addresses starting from a latched base.
// Each pixel: SETUP (addr/data, we_n=1), WRITE (we_n=0 for WR_CYCLES), HOLD.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   pix              : frame control / pixel handshake (image_writer_if.slave)
//   o_sram_address   : SRAM word address
//   io_sram_data     : SRAM data, driven only in SETUP/WRITE/HOLD
//   o_sram_*_n       : active-low SRAM strobes (oe_n tied inactive)
// All outputs are registered; they are decoded from the next state so that
// they line up with the state they belong to.
// -----------------------------------------------------------------------------
module image_writer
   import image_pkg::*;
#(
   parameter int unsigned       WR_CYCLES    = 2,
   parameter logic [ADDR_W-1:0] FRAME_PIXELS = 20'd307200
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   image_writer_if.slave     pix,
   output logic [ADDR_W-1:0] o_sram_address,
   inout  wire  [DATA_W-1:0] io_sram_data,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_ce_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n
);

   state_e              state_q,   state_d;
   logic [ADDR_W-1:0]   address_q, address_d;
   logic [ADDR_W-1:0]   count_q,   count_d;
   logic [DATA_W-1:0]   data_q,    data_d;
   logic                ready_q,   ready_d;
   logic                we_n_q,    we_n_d;
   logic                drive_q,   drive_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;
   logic                strb_n_q,  strb_n_d;

   logic                timer_load;
   logic                timer_done;
   logic [ADDR_W-1:0]   count_inc;

   sram_write_timer #(
      .WR_CYCLES (WR_CYCLES)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (timer_load),
      .o_done  (timer_done)
   );

   assign count_inc = count_q + 20'd1;

   // Writer FSM: next state, datapath updates and next-state output decode.
   always_comb begin
      state_d    = state_q;
      address_d  = address_q;
      count_d    = count_q;
      data_d     = data_q;
      timer_load = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pix.i_start) begin
               state_d   = ST_WAIT;
               address_d = pix.i_base_address;
               count_d   = 20'd0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // o_ready is high exactly in WAIT, so i_valid alone means transfer.
            if (pix.i_valid) begin
               state_d = ST_SETUP;
               data_d  = pack_rgb5551(pix.i_pixel);
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_SETUP: begin
            state_d    = ST_WRITE;
            timer_load = 1'b1;
         end
         ST_WRITE: begin
            if (timer_done) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_HOLD: begin
            // Address wraps naturally at 20 bits.
            address_d = address_q + 20'd1;
            count_d   = count_inc;
            if (count_inc == FRAME_PIXELS) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d  = (state_d == ST_WAIT);
      we_n_d   = (state_d != ST_WRITE);
      drive_d  = (state_d == ST_SETUP) || (state_d == ST_WRITE) || (state_d == ST_HOLD);
      busy_d   = (state_d == ST_WAIT) || drive_d;
      done_d   = (state_d == ST_DONE);
      strb_n_d = !busy_d;
   end

   // State, datapath and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         address_q <= 20'd0;
         count_q   <= 20'd0;
         data_q    <= 16'd0;
         ready_q   <= 1'b0;
         we_n_q    <= 1'b1;
         drive_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         strb_n_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         count_q   <= count_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         we_n_q    <= we_n_d;
         drive_q   <= drive_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         strb_n_q  <= strb_n_d;
      end
   end

   assign io_sram_data   = drive_q ? data_q : 16'hzzzz;
   assign o_sram_address = address_q;
   assign o_sram_we_n    = we_n_q;
   assign o_sram_oe_n    = 1'b1;
   assign o_sram_ce_n    = strb_n_q;
   assign o_sram_lb_n    = strb_n_q;
   assign o_sram_ub_n    = strb_n_q;

   assign pix.o_ready    = ready_q;
   assign pix.o_busy     = busy_q;
   assign pix.o_done     = done_q;
   assign pix.o_count    = count_q;

endmodule

// File: doc/image_writer.md
IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 Parameter WR_CYCLES, default 2: width of the SRAM write-enable low pulse in clocks; the legal range is 1..15.
REQ-002 Parameter FRAME_PIXELS, default 20'd307200: number of pixels per frame; the legal range is 1..2^20-1.
REQ-003 The block has one clock; reset is asynchronous and active-low.
REQ-004 i_clk  in  1  the single clock; all state SHALL change on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  starts a frame; it SHALL be sampled only in IDLE.
REQ-007 i_base_address  in  20  first SRAM word address of the frame; it SHALL be latched on an accepted i_start.
REQ-008 i_valid  in  1  pixel valid.
REQ-009 i_pixel  in  32  RGBA8888 pixel: R in [31:24], G in [23:16], B in [15:8], A in [7:0].
REQ-010 o_ready  out  1  pixel ready.
REQ-011 o_sram_address  out  20  SRAM word address.
REQ-012 io_sram_data  inout  16  SRAM data bus; high-Z when not driving.
REQ-013 o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  active-low SRAM strobes.
REQ-014 o_busy  out  1  frame in progress.
REQ-015 o_done  out  1  one-cycle pulse at frame end.
REQ-016 o_count  out  20  pixels written in the current or last frame.

Function
REQ-017 States SHALL be IDLE, WAIT, SETUP, WRITE, HOLD and DONE.
REQ-018 IDLE with i_start=1 -> WAIT; the block SHALL load address<=i_base_address and count<=0.
REQ-019 i_start SHALL be ignored in every state other than IDLE.
REQ-020 o_ready SHALL be 1 only in WAIT; a pixel transfer occurs on a clock edge with i_valid&&o_ready, and the pixel is latched on that edge.
REQ-021 WAIT with a transfer -> SETUP; WAIT without a transfer SHALL stay in WAIT for any length of time.
REQ-022 Packing: data = {R[7:3], G[7:3], B[7:3], A[7]}.
REQ-023 SETUP lasts 1 cycle: address and data are driven and we_n=1.
REQ-024 WRITE lasts exactly WR_CYCLES cycles with we_n=0, counted by an internal 4-bit timer.
REQ-025 HOLD lasts 1 cycle: we_n=1 and data is still driven.
REQ-026 On the HOLD exit edge, address SHALL increment by 1 and count SHALL increment by 1.
REQ-027 After HOLD, the next state SHALL be DONE if the new count equals FRAME_PIXELS, otherwise WAIT.
REQ-028 The address SHALL wrap from 20'hFFFFF to 20'h00000 without any error indication.
REQ-029 io_sram_data SHALL be driven only in SETUP, WRITE and HOLD, and SHALL be 16'hZZZZ in all other states.
REQ-030 o_sram_ce_n, o_sram_lb_n and o_sram_ub_n SHALL be 0 while o_busy=1 and 1 otherwise.
REQ-031 o_sram_oe_n SHALL be 1 at all times.
REQ-032 o_busy SHALL be 1 in the states WAIT through HOLD.
REQ-033 DONE lasts 1 cycle with o_done=1 and then goes to IDLE.
REQ-034 o_count SHALL hold its final value in IDLE until the next accepted i_start.
REQ-035 Pixel throughput: accept edge k, SETUP in cycle k+1, WRITE in cycles k+2..k+1+WR_CYCLES, HOLD in cycle k+2+WR_CYCLES; the next acceptance is no earlier than edge k+3+WR_CYCLES.
REQ-036 i_pixel changes while not in WAIT SHALL NOT affect the bus data.
REQ-037 i_valid=1 in IDLE SHALL be ignored and no pixel is accepted.

Reset
REQ-038 Asserting i_rst_n=0 SHALL immediately force state=IDLE, o_sram_we_n=1, data bus high-Z, o_ready=0, o_busy=0, o_done=0, o_count=0, o_sram_address=0, and ce_n/lb_n/ub_n/oe_n=1.
REQ-039 A reset during WRITE SHALL abort the write without a completion pulse.
REQ-040 After reset release, the block SHALL need a new i_start before it accepts pixels.

Structure
REQ-041 The state enum and the RGBA8888-to-RGB5551 packing function SHALL be placed in shared package image_pkg.
REQ-042 FRAME_PIXELS remains a module parameter.
REQ-043 Sub-module sram_write_timer (the WR_CYCLES down-counter with a done flag) is permitted; the rest of the logic stays in one FSM.

Verification
REQ-044 Frame of 3 pixels (FRAME_PIXELS=3, base 20'h00100), pixels 32'hFF0000FF, 32'h00FF0000, 32'h0000FF80 -> SRAM words 16'hF801 @0x100, 16'h07C0 @0x101, 16'h003F @0x102, then one o_done pulse and o_count=3.
REQ-045 WR_CYCLES=2 with i_valid held at 1 -> we_n is low for exactly 2 cycles per pixel, pixels are accepted every 5 cycles, and data is stable from SETUP through HOLD.
REQ-046 Base address 20'hFFFFF with FRAME_PIXELS=2 -> the writes land at 0xFFFFF and then 0x00000.
REQ-047 i_valid deasserted for 10 cycles in WAIT, and i_start pulsed mid-frame -> the FSM stays in WAIT, the bus stays Z, and the restart is ignored with the address unchanged.
REQ-048 i_rst_n pulled low in the 1st WRITE cycle -> in the same cycle we_n=1, the bus is Z and o_busy=0, with no o_done pulse.
